// File: rtl/rx_timer_pkg.sv
// rtl/rx_timer_pkg.sv - shared types and constants for the receive byte timer
package rx_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rx_state_e;

  localparam int BITS_PER_BYTE        = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 8;
  localparam int DEFAULT_SAMPLE_PHASE = 3;

endpackage

// File: rtl/rx_phase_counter.sv
// rtl/rx_phase_counter.sv - bit phase counter, counts 1..rollover_val, clear forces 0
module rx_phase_counter (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       count_enable,
  input  logic [3:0] rollover_val,
  output logic [3:0] count_out
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 4'd0;
    end else if (count_enable) begin
      count_d = (count_q >= rollover_val) ? 4'd1 : count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/rx_byte_timer.sv
// rtl/rx_byte_timer.sv - serial receive bit/byte timing; RX_TIMER_STUFF_EN lets stuff_bit suppress a sample strobe
module rx_byte_timer
  import rx_timer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SAMPLE_PHASE = DEFAULT_SAMPLE_PHASE
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rcving,
  input  logic       d_edge,
  input  logic       stuff_bit,
  output logic       shift_enable,
  output logic       byte_received,
  output logic [3:0] bit_count,
  output logic       busy
);

  localparam logic [3:0] ROLLOVER    = 4'(CLKS_PER_BIT);
  localparam logic [3:0] SAMPLE_AT   = 4'(SAMPLE_PHASE);
  localparam logic [3:0] SAMPLE_PREV = SAMPLE_AT - 4'd1;
  localparam logic [3:0] LAST_BIT    = 4'(BITS_PER_BYTE - 1);
  localparam logic [3:0] FULL_BYTE   = 4'(BITS_PER_BYTE);

  rx_state_e  state_q, state_d;
  logic       shift_enable_q, shift_enable_d;
  logic       byte_received_q, byte_received_d;
  logic [3:0] bit_count_q, bit_count_d;
  logic       busy_q, busy_d;

  logic       running;
  logic       phase_clear;
  logic [3:0] phase_q;
  logic       phase_hits;
  logic       stuff_ok;

  assign running     = (state_q == RUN) && rcving;
  assign phase_clear = !running || d_edge;

  rx_phase_counter u_phase (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (phase_clear),
    .count_enable (running),
    .rollover_val (ROLLOVER),
    .count_out    (phase_q)
  );

  // Phase is about to become SAMPLE_AT on this edge (including the wrap when sampling at 1).
  assign phase_hits = (phase_q == SAMPLE_PREV) ||
                      ((SAMPLE_AT == 4'd1) && (phase_q >= ROLLOVER));

`ifdef RX_TIMER_STUFF_EN
  assign stuff_ok = !stuff_bit;
`else
  logic stuff_bit_unused;
  assign stuff_bit_unused = stuff_bit;
  assign stuff_ok         = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rcving)  state_d = RUN;
      RUN:     if (!rcving) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_enable_d  = running && !d_edge && phase_hits && stuff_ok;
    byte_received_d = 1'b0;
    bit_count_d     = 4'd0;
    busy_d          = (state_d == RUN);
    if (running) begin
      if (bit_count_q == FULL_BYTE) begin
        bit_count_d = shift_enable_q ? 4'd1 : 4'd0;
      end else if (shift_enable_q) begin
        bit_count_d = bit_count_q + 4'd1;
      end else begin
        bit_count_d = bit_count_q;
      end
      byte_received_d = shift_enable_q && (bit_count_q == LAST_BIT);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      shift_enable_q  <= 1'b0;
      byte_received_q <= 1'b0;
      bit_count_q     <= 4'd0;
      busy_q          <= 1'b0;
    end else begin
      shift_enable_q  <= shift_enable_d;
      byte_received_q <= byte_received_d;
      bit_count_q     <= bit_count_d;
      busy_q          <= busy_d;
    end
  end

  assign shift_enable  = shift_enable_q;
  assign byte_received = byte_received_q;
  assign bit_count     = bit_count_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_rx_byte_timer.sv
// tb/tb_rx_byte_timer.sv - directed self-checking bench for rx_byte_timer
module tb_rx_byte_timer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rcving;
  logic       d_edge;
  logic       stuff_bit;
  logic       shift_enable;
  logic       byte_received;
  logic [3:0] bit_count;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         edge_no;
    logic       exp_shift;
    logic       exp_byte;
    logic [3:0] exp_cnt;
    logic       exp_busy;
  } vec_t;

  vec_t nominal [10];

  rx_byte_timer #(
    .CLKS_PER_BIT (8),
    .SAMPLE_PHASE (3)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .rcving        (rcving),
    .d_edge        (d_edge),
    .stuff_bit     (stuff_bit),
    .shift_enable  (shift_enable),
    .byte_received (byte_received),
    .bit_count     (bit_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Park in IDLE; the next step() is edge 0 of a new byte.
  task automatic go_idle();
    rcving    = 1'b0;
    d_edge    = 1'b0;
    stuff_bit = 1'b0;
    step();
    rcving = 1'b1;
  endtask

  initial begin
    nominal[0] = '{0,  1'b0, 1'b0, 4'd0, 1'b1};
    nominal[1] = '{2,  1'b0, 1'b0, 4'd0, 1'b1};
    nominal[2] = '{3,  1'b1, 1'b0, 4'd0, 1'b1};
    nominal[3] = '{4,  1'b0, 1'b0, 4'd1, 1'b1};
    nominal[4] = '{11, 1'b1, 1'b0, 4'd1, 1'b1};
    nominal[5] = '{12, 1'b0, 1'b0, 4'd2, 1'b1};
    nominal[6] = '{59, 1'b1, 1'b0, 4'd7, 1'b1};
    nominal[7] = '{60, 1'b0, 1'b1, 4'd8, 1'b1};
    nominal[8] = '{61, 1'b0, 1'b0, 4'd0, 1'b1};
    nominal[9] = '{62, 1'b0, 1'b0, 4'd0, 1'b1};

    // Reset held for two edges with rcving high
    n_rst = 1'b0; rcving = 1'b1; d_edge = 1'b0; stuff_bit = 1'b0;
    step();
    step();
    check("rst_shift", shift_enable, 0);
    check("rst_byte", byte_received, 0);
    check("rst_cnt", bit_count, 0);
    check("rst_busy", busy, 0);
    n_rst = 1'b1;

    // Nominal byte
    go_idle();
    for (int e = 0; e <= 62; e++) begin
      step();
      check($sformatf("nom_shift_e%0d", e), shift_enable,
            (e >= 3 && e <= 59 && (e % 8) == 3) ? 1 : 0);
      for (int i = 0; i < 10; i++) begin
        if (nominal[i].edge_no == e) begin
          check($sformatf("nom_vshift_e%0d", e), shift_enable, nominal[i].exp_shift);
          check($sformatf("nom_byte_e%0d", e), byte_received, nominal[i].exp_byte);
          check($sformatf("nom_cnt_e%0d", e), bit_count, nominal[i].exp_cnt);
          check($sformatf("nom_busy_e%0d", e), busy, nominal[i].exp_busy);
        end
      end
    end

    // Resync on d_edge at edge 6
    go_idle();
    for (int e = 0; e <= 18; e++) begin
      d_edge = (e == 6);
      step();
      d_edge = 1'b0;
      check($sformatf("resync_shift_e%0d", e), shift_enable,
            (e == 3 || e == 9 || e == 17) ? 1 : 0);
    end
    check("resync_cnt", bit_count, 3);

    // Abort at edge 35
    go_idle();
    for (int e = 0; e <= 34; e++) step();
    check("abort_cnt_before", bit_count, 4);
    rcving = 1'b0;
    step();
    check("abort_busy", busy, 0);
    check("abort_cnt", bit_count, 0);
    check("abort_shift", shift_enable, 0);
    for (int k = 0; k < 30; k++) begin
      step();
      check($sformatf("abort_quiet_%0d", k), {shift_enable, byte_received}, 0);
    end
    check("abort_busy_end", busy, 0);

    // rcving dropped exactly when the byte would complete
    go_idle();
    for (int e = 0; e <= 59; e++) step();
    check("drop_shift_e59", shift_enable, 1);
    rcving = 1'b0;
    step();
    check("drop_byte", byte_received, 0);
    check("drop_cnt", bit_count, 0);
    check("drop_busy", busy, 0);
    step();
    check("drop_byte_late", byte_received, 0);

    // Stuffed bit at edge 19
    go_idle();
    for (int e = 0; e <= 70; e++) begin
      stuff_bit = (e == 19);
      step();
      stuff_bit = 1'b0;
`ifdef RX_TIMER_STUFF_EN
      if (e == 19) check("stuff_shift_e19", shift_enable, 0);
      if (e == 20) check("stuff_cnt_e20", bit_count, 2);
      if (e == 60) check("stuff_byte_e60", byte_received, 0);
      if (e == 68) check("stuff_byte_e68", byte_received, 1);
      if (e == 69) check("stuff_cnt_e69", bit_count, 0);
`else
      if (e == 19) check("stuff_shift_e19", shift_enable, 1);
      if (e == 20) check("stuff_cnt_e20", bit_count, 3);
      if (e == 60) check("stuff_byte_e60", byte_received, 1);
      if (e == 68) check("stuff_byte_e68", byte_received, 0);
      if (e == 69) check("stuff_cnt_e69", bit_count, 1);
`endif
    end

    // Reset at edge 30 mid-byte, then restart
    go_idle();
    for (int e = 0; e <= 30; e++) begin
      n_rst = (e == 30) ? 1'b0 : 1'b1;
      step();
      if (e == 29) check("mrst_cnt_before", bit_count, 4);
    end
    check("mrst_cnt", bit_count, 0);
    check("mrst_busy", busy, 0);
    check("mrst_shift", shift_enable, 0);
    check("mrst_byte", byte_received, 0);
    n_rst  = 1'b1;
    rcving = 1'b1;
    for (int r = 0; r <= 40; r++) begin
      step();
      if (r == 0) check("mrst_busy_r0", busy, 1);
      check($sformatf("mrst_shift_r%0d", r), shift_enable, (r >= 3 && (r % 8) == 3) ? 1 : 0);
      check($sformatf("mrst_byte_r%0d", r), byte_received, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_byte_timer.md
RX_BYTE_TIMER -- requirements
Module: rx_byte_timer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clocks per serial bit period (legal 4..15).
REQ-002 SHALL have parameter SAMPLE_PHASE, default 3, phase count at which a bit is sampled (legal 1..CLKS_PER_BIT).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port n_rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port rcving  input  1  packet reception in progress.
REQ-006 SHALL have port d_edge  input  1  line transition detected; resynchronises the bit phase.
REQ-007 SHALL have port stuff_bit  input  1  the current bit is a stuffed bit.
REQ-008 SHALL have port shift_enable  output  1  one-cycle strobe to shift the sampled bit.
REQ-009 SHALL have port byte_received  output  1  one-cycle strobe after 8 bits are shifted.
REQ-010 SHALL have port bit_count  output  4  bits shifted in the current byte, 0..8.
REQ-011 SHALL have port busy  output  1  high while in state RUN.

Function
REQ-012 SHALL implement states IDLE and RUN; IDLE->RUN at an edge sampling rcving=1; RUN->IDLE at an edge sampling rcving=0.
REQ-013 SHALL hold the phase counter at 0 on IDLE->RUN entry, then increment it 1..CLKS_PER_BIT each edge in RUN, wrapping CLKS_PER_BIT->1.
REQ-014 SHALL, at an edge in RUN sampling d_edge=1, load the phase counter with 0, overriding the increment.
REQ-015 SHALL register shift_enable high for one cycle after any edge at which the phase counter becomes SAMPLE_PHASE, with rcving=1 and d_edge=0 sampled.
REQ-016 SHALL increment bit_count at each edge sampling shift_enable=1.
REQ-017 SHALL, at the edge where bit_count becomes 8, set byte_received for one cycle; bit_count SHALL return to 0 on the following edge.
REQ-018 SHALL give rcving=0 priority over every other event: no shift_enable or byte_received after that edge; counters cleared to 0; a pending byte_received is dropped.
REQ-019 SHALL have outputs driven from registers only, with no combinational input-to-output path.

Reset
REQ-020 SHALL, at an edge sampling n_rst=0, enter IDLE and clear the phase counter, bit_count, shift_enable, byte_received and busy to 0, overriding all inputs.
REQ-021 SHALL, when reset occurs mid-byte, discard the partial byte and issue no byte_received.

Configuration
REQ-022 SHALL honour macro RX_TIMER_STUFF_EN.
- Defined: stuff_bit=1 sampled at the edge where the phase becomes SAMPLE_PHASE suppresses that shift_enable; bit_count is unchanged.
- Undefined: the stuff_bit port exists but is ignored.

Structure
REQ-023 SHALL take the following from shared package rx_timer_pkg:
- state enum typedef (IDLE, RUN)
- constant BITS_PER_BYTE=8
- default values of CLKS_PER_BIT and SAMPLE_PHASE.
REQ-024 SHALL instantiate one sub-module, rx_phase_counter: synchronous-reset rollover counter with clear, enable and rollover-value inputs, used as the phase counter.

Verification (CLKS_PER_BIT=8, SAMPLE_PHASE=3; edge 0 is the first edge sampling rcving=1)
REQ-025 SHALL cover reset: n_rst=0 for 2 edges with rcving=1 -> all outputs 0, busy 0.
REQ-026 SHALL cover a nominal byte: rcving held 1 -> shift_enable high after edges 3, 11, ..., 59; bit_count 8 and byte_received 1 after edge 60; bit_count 0 after edge 61.
REQ-027 SHALL cover resync: d_edge=1 at edge 6 -> no strobe at edge 11; next shift_enable after edge 9, then after edge 17.
REQ-028 SHALL cover abort: rcving=0 sampled at edge 35 -> busy 0, bit_count 0 after edge 35; no further strobes.
REQ-029 SHALL cover stuffing: with RX_TIMER_STUFF_EN defined, stuff_bit=1 at edge 19 -> no shift_enable after edge 19, bit_count stays 2, byte_received after edge 68.
REQ-030 SHALL cover mid-byte reset: n_rst=0 at edge 30 -> bit_count 0, busy 0; no byte_received; after release with rcving=1, counting restarts from phase 0.
